uart_rx: RTL and testbench

UART serial receiver: the receiving end of the link whose transmit side is paced by the baud generator's `BaudTick`. It consumes a 16x-oversampled tick and the asynchronous `rxd` line, and recovers 8N1 frames (optional even parity). Each byte goes to the processor-side consumer through a one-entry valid/ready holding register. It sits between the board RX pin and the pipeline processor's memory-mapped I/O.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx.sv | 179 +++++++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
// Intended to be reused by the companion transmitter.
package uart_pkg;

  localparam int UART_OVERSAMPLE_DEF = 16;
  localparam int UART_DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// parameterised reset value so an idle-high line does not look active out of reset.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// Oversampled UART receiver (start + DATA_BITS + stop) feeding a one-entry
// valid/ready holding register. Define UART_RX_PARITY_EN to add an even-parity bit and parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS_DEF,
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_rx_state_t       state;
  uart_rx_state_t       state_nxt;
  logic                 rxd_s;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick_mid;
  logic                 tick_end;
  logic                 par_ok;
  logic                 start_ok;
  logic                 shift_en;
  logic                 load;
  logic                 ferr_set;
  logic                 ovr_set;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
  logic                 par_en;
  logic                 perr_set;
`endif

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  // Once START has aligned the counter to mid-bit, every later wrap lands mid-bit too.
  assign tick_mid = baud_tick && (cnt == CNT_MID);
  assign tick_end = baud_tick && (cnt == CNT_END);

`ifdef UART_RX_PARITY_EN
  assign par_ok = ~(^{shreg, par_bit});
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!rxd_s) state_nxt = ST_START;
      ST_START:  if (tick_mid) state_nxt = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (tick_end && (idx == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (tick_end) state_nxt = ST_STOP;
`endif
      ST_STOP:   if (tick_end) state_nxt = rxd_s ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rxd_s) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // A good frame loads only if the holding register is empty or draining this cycle.
  always_comb begin
    start_ok = 1'b0;
    shift_en = 1'b0;
    load     = 1'b0;
    ferr_set = 1'b0;
    ovr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en   = 1'b0;
    perr_set = 1'b0;
`endif
    case (state)
      ST_START: start_ok = tick_mid && !rxd_s;
      ST_DATA:  shift_en = tick_end;
`ifdef UART_RX_PARITY_EN
      ST_PARITY: par_en = tick_end;
`endif
      ST_STOP: begin
        if (tick_end) begin
          ferr_set = !rxd_s;
`ifdef UART_RX_PARITY_EN
          perr_set = !par_ok;
`endif
          if (rxd_s && par_ok) begin
            if (rx_valid && !rx_ready) ovr_set = 1'b1;
            else                       load    = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            cnt <= '0;
    else if (state == ST_IDLE || state == ST_BREAK || start_ok) cnt <= '0;
    else if (tick_end)                                     cnt <= '0;
    else if (baud_tick)                                    cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      shreg <= '0;
    end else begin
      if (start_ok)      idx <= '0;
      else if (shift_en) idx <= idx + IDX_W'(1);
      if (shift_en) shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      par_bit <= 1'b0;
    else if (par_en) par_bit <= rxd_s;
  end
`endif

  // Holding register: a new load beats a simultaneous handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        rx_valid <= 1'b1;
        rx_data  <= shreg;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
      frame_err <= ferr_set;
      overrun   <= ovr_set;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= perr_set;
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic checked
// against a frame-level model of the receiver's delivery, overrun and error rules.
module tb_uart_rx;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int TICK_DIV   = 2;
  localparam int BIT_CLK    = OVERSAMPLE * TICK_DIV;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 baud_tick = 1'b0;
  logic                 rxd = 1'b1;
  logic                 rx_ready = 1'b0;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 overrun;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
  int                   perr_cnt = 0;
  int                   exp_perr = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int vcyc     = 0;
  int deliv    = 0;
  int exp_ferr = 0;
  int exp_ovr  = 0;
  bit model_full = 1'b0;
  logic [DATA_BITS-1:0] exp_q[$];
  int div = 0;

  uart_rx #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_tick  (baud_tick),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk); #1;
      baud_tick = (div == 0);
      div = (div + 1) % TICK_DIV;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observe flag pulses and consumer handshakes; every delivered byte is checked in order.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [31:0] want;
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) perr_cnt++;
`endif
      if (rx_valid) vcyc++;
      if (rx_valid && rx_ready) begin
        deliv++;
        model_full = 1'b0;
        want = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
        check("rx_data", 32'(rx_data), want);
      end
    end
  end

  task automatic put(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    put(1'b1, n);
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop, input int extra_low
`ifdef UART_RX_PARITY_EN
                            , input logic pbit
`endif
                            );
    bit par_ok;
    par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_ok = (((^d) ^ pbit) == 1'b0);
    if (!par_ok) exp_perr++;
`endif
    if (!stop)        exp_ferr++;
    else if (!par_ok) ;
    else if (model_full) exp_ovr++;
    else begin
      model_full = 1'b1;
      exp_q.push_back(d);
    end
    put(1'b0, BIT_CLK);
    for (int i = 0; i < DATA_BITS; i++) put(d[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
    put(pbit, BIT_CLK);
`endif
    put(stop, BIT_CLK);
    if (!stop) put(1'b0, extra_low * BIT_CLK);
    rxd = 1'b1;
  endtask

  task automatic send(input logic [DATA_BITS-1:0] d, input logic stop, input int extra_low);
`ifdef UART_RX_PARITY_EN
    send_frame(d, stop, extra_low, ^d);
`else
    send_frame(d, stop, extra_low);
`endif
  endtask

  initial begin
    int s_deliv, s_vcyc, s_ferr, s_ovr;
    logic [DATA_BITS-1:0] d5a;
    logic [DATA_BITS-1:0] rd;

    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    idle(2 * BIT_CLK);

    // Basic frame with consumer ready
    rx_ready = 1'b1;
    s_deliv = deliv; s_vcyc = vcyc; s_ferr = ferr_cnt; s_ovr = ovr_cnt;
    send(8'hA5, 1'b1, 0);
    idle(BIT_CLK);
    check("a5_delivered", 32'(deliv - s_deliv), 32'd1);
    check("a5_valid_cycles", 32'(vcyc - s_vcyc), 32'd1);
    check("a5_no_flags", 32'((ferr_cnt - s_ferr) + (ovr_cnt - s_ovr)), 32'd0);

    // Short glitch: false start
    s_deliv = deliv; s_ferr = ferr_cnt;
    put(1'b0, 4 * TICK_DIV);
    idle(3 * BIT_CLK);
    check("glitch_no_valid", 32'(deliv - s_deliv), 32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt - s_ferr), 32'd0);

    // Stop bit low, line held low for two bit times
    s_deliv = deliv; s_ferr = ferr_cnt; s_vcyc = vcyc;
    send(8'h3C, 1'b0, 1);
    idle(12 * BIT_CLK);
    check("ferr_pulse", 32'(ferr_cnt - s_ferr), 32'd1);
    check("ferr_no_valid", 32'(vcyc - s_vcyc), 32'd0);
    s_deliv = deliv;
    send(8'h4B, 1'b1, 0);
    idle(BIT_CLK);
    check("after_break_delivered", 32'(deliv - s_deliv), 32'd1);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    s_ovr = ovr_cnt;
    send(8'h11, 1'b1, 0);
    idle(BIT_CLK);
    send(8'h22, 1'b1, 0);
    idle(BIT_CLK);
    check("ovr_valid_held", 32'(rx_valid), 32'd1);
    check("ovr_data_kept", 32'(rx_data), 32'h11);
    check("ovr_pulse", 32'(ovr_cnt - s_ovr), 32'd1);
    s_deliv = deliv;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ovr_drain", 32'(deliv - s_deliv), 32'd1);
    check("ovr_valid_drop", 32'(rx_valid), 32'd0);

    // Reset mid-frame with a byte already held
    rx_ready = 1'b0;
    send(8'h66, 1'b1, 0);
    idle(BIT_CLK);
    check("pre_reset_full", 32'(rx_valid), 32'd1);
    s_ferr = ferr_cnt; s_ovr = ovr_cnt;
    d5a = 8'h5A;
    put(1'b0, BIT_CLK);
    for (int i = 0; i < 3; i++) put(d5a[i], BIT_CLK);
    put(d5a[3], BIT_CLK / 2);
    rst_n = 1'b0;
    #1;
    check("midreset_rx_valid", 32'(rx_valid), 32'd0);
    check("midreset_rx_data", 32'(rx_data), 32'h0);
    check("midreset_flags", 32'({frame_err, overrun}), 32'd0);
    exp_q.delete();
    model_full = 1'b0;
    rxd = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(BIT_CLK);
    rx_ready = 1'b1;
    s_deliv = deliv;
    send(8'h81, 1'b1, 0);
    idle(BIT_CLK);
    check("post_reset_delivered", 32'(deliv - s_deliv), 32'd1);
    check("post_reset_no_flags", 32'((ferr_cnt - s_ferr) + (ovr_cnt - s_ovr)), 32'd0);

`ifdef UART_RX_PARITY_EN
    s_deliv = deliv;
    send_frame(8'h07, 1'b1, 0, 1'b1);
    idle(BIT_CLK);
    send_frame(8'h07, 1'b1, 0, 1'b0);
    idle(BIT_CLK);
    check("parity_good_delivered", 32'(deliv - s_deliv), 32'd1);
`endif

    // Randomized traffic, consumer always ready
    for (int k = 0; k < 16; k++) begin
      rd = DATA_BITS'($urandom);
      send(rd, ($urandom_range(0, 5) != 0), int'($urandom_range(0, 1)));
      idle(BIT_CLK * (1 + int'($urandom_range(0, 1))) + int'($urandom_range(0, 7)));
    end

    idle(2 * BIT_CLK);
    check("total_frame_err", 32'(ferr_cnt), 32'(exp_ferr));
    check("total_overrun", 32'(ovr_cnt), 32'(exp_ovr));
    check("undelivered_bytes", 32'(exp_q.size()), 32'd0);
`ifdef UART_RX_PARITY_EN
    check("total_parity_err", 32'(perr_cnt), 32'(exp_perr));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
